// File: rtl/mpc_types.sv
// Shared types for the issue unit: configuration record, ISU op codes,
// pending-entry state and the pending-entry record.
package mpc_types;

  typedef struct packed {
    int unsigned wayNum;
    int unsigned setWidth;
    int unsigned wayWidth;
    int unsigned offsetWidth;
    int unsigned wbufWidth;
  } mpc_cfg_t;

  localparam int unsigned DEF_SET_W    = 4;
  localparam int unsigned DEF_WAY_W    = 2;
  localparam int unsigned DEF_OFFSET_W = 3;
  localparam int unsigned DEF_WBUF_W   = 2;

  localparam logic [2:0] OP_RD_HIT  = 3'b000;
  localparam logic [2:0] OP_WR_HIT  = 3'b001;
  localparam logic [2:0] OP_RD_MISS = 3'b100;
  localparam logic [2:0] OP_WR_MISS = 3'b101;

  typedef enum logic [1:0] {
    INVALID = 2'd0,
    WAIT    = 2'd1,
    READY   = 2'd2
  } isu_entry_state_e;

  typedef struct packed {
    logic [2:0]                      channel_1hot_id;
    logic [2:0]                      op;
    logic [DEF_WAY_W+DEF_SET_W-1:0]  id;
    logic [DEF_OFFSET_W-1:0]         offset;
    logic [DEF_WBUF_W-1:0]           wbuf_id;
  } isu_pend_entry_t;

  // A zero field in the config falls back to the default width.
  function automatic int unsigned cfg_w(int unsigned w, int unsigned dflt);
    return (w != 0) ? w : dflt;
  endfunction

  function automatic int unsigned cfg_way_w(mpc_cfg_t c);
    if (c.wayWidth != 0) return c.wayWidth;
    if (c.wayNum > 1) return $clog2(c.wayNum);
    return DEF_WAY_W;
  endfunction

endpackage

// File: rtl/isu_pend_fifo.sv
// Circular storage with write/read pointers and occupancy count.
// All slots are exposed so the owner can match against stored ids.
module isu_pend_fifo
  import mpc_types::*;
#(
  parameter type entry_t  = isu_pend_entry_t,
  parameter int  Depth    = 8,
  localparam int PtrW     = $clog2(Depth)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_push,
  input  entry_t          i_data,
  input  logic            i_pop,
  output entry_t          o_entries [Depth],
  output logic [PtrW-1:0] o_wr_ptr,
  output logic [PtrW-1:0] o_rd_ptr,
  output logic            o_full
);

  entry_t          r_mem [Depth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW:0]   r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (i_push && !i_pop)      r_count <= r_count + (PtrW+1)'(1);
      else if (!i_push && i_pop) r_count <= r_count - (PtrW+1)'(1);
    end
  end

  assign o_entries = r_mem;
  assign o_wr_ptr  = r_wr_ptr;
  assign o_rd_ptr  = r_rd_ptr;
  assign o_full    = (r_count == (PtrW+1)'(Depth));

endmodule

// File: rtl/isu_pend_queue.sv
// ISU input stage: in-order pending queue that holds misses until their line
// is refilled, dispatches the head to the executor and returns a credit per request.
//
// state   | meaning
// INVALID | slot free
// WAIT    | miss, waiting for refill of its {way,set}
// READY   | eligible to dispatch once it reaches the head
module isu_pend_queue
  import mpc_types::*;
#(
  parameter mpc_cfg_t Cfg             = '0,
  parameter type      setWidth_t      = logic [cfg_w(Cfg.setWidth, DEF_SET_W)-1:0],
  parameter type      wayIndexWidth_t = logic [cfg_way_w(Cfg)-1:0],
  parameter type      nlineWidth_t    = logic [cfg_way_w(Cfg)+cfg_w(Cfg.setWidth, DEF_SET_W)-1:0],
  parameter type      offsetWidth_t   = logic [cfg_w(Cfg.offsetWidth, DEF_OFFSET_W)-1:0],
  parameter type      wbufWidth_t     = logic [cfg_w(Cfg.wbufWidth, DEF_WBUF_W)-1:0],
  parameter int       Depth           = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           u_htu_valid,
  output logic           u_htu_ready,
  input  logic [2:0]     u_htu_channel_1hot_id,
  input  logic [2:0]     u_htu_op,
  input  nlineWidth_t    u_htu_id,
  input  offsetWidth_t   u_htu_offset,
  input  wbufWidth_t     u_htu_wbuf_id,
  input  logic           u_htu_refill_valid,
  input  setWidth_t      u_htu_refill_set,
  input  wayIndexWidth_t u_htu_refill_way,
  output logic           d_exe_valid,
  input  logic           d_exe_ready,
  output logic [2:0]     d_exe_channel_1hot_id,
  output logic [2:0]     d_exe_op,
  output nlineWidth_t    d_exe_id,
  output offsetWidth_t   d_exe_offset,
  output wbufWidth_t     d_exe_wbuf_id,
  output logic           u_htu_crdt_valid,
  output nlineWidth_t    u_htu_crdt_way_set
);

  localparam int PtrW = $clog2(Depth);

  typedef struct packed {
    logic [2:0]   channel_1hot_id;
    logic [2:0]   op;
    nlineWidth_t  id;
    offsetWidth_t offset;
    wbufWidth_t   wbuf_id;
  } entry_t;

  entry_t           w_in;
  entry_t           w_head;
  entry_t           w_entries [Depth];
  logic [PtrW-1:0]  w_wr_ptr;
  logic [PtrW-1:0]  w_rd_ptr;
  logic             w_full;
  logic             w_enq;
  logic             w_deq;
  logic             w_enq_bypass;
  nlineWidth_t      w_refill_id;
  isu_entry_state_e r_state [Depth];
  logic             r_crdt_valid;
  nlineWidth_t      r_crdt_way_set;

  assign w_in         = '{channel_1hot_id: u_htu_channel_1hot_id, op: u_htu_op,
                          id: u_htu_id, offset: u_htu_offset, wbuf_id: u_htu_wbuf_id};
  assign w_refill_id  = {u_htu_refill_way, u_htu_refill_set};
  assign u_htu_ready  = ~w_full;
  assign w_enq        = u_htu_valid & u_htu_ready;
  assign w_head       = w_entries[w_rd_ptr];
  assign d_exe_valid  = (r_state[w_rd_ptr] == READY);
  assign w_deq        = d_exe_valid & d_exe_ready;
  // A miss arriving with its own refill would otherwise miss the match forever.
  assign w_enq_bypass = u_htu_refill_valid && (u_htu_id == w_refill_id);

  isu_pend_fifo #(
    .entry_t (entry_t),
    .Depth   (Depth)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_enq),
    .i_data    (w_in),
    .i_pop     (w_deq),
    .o_entries (w_entries),
    .o_wr_ptr  (w_wr_ptr),
    .o_rd_ptr  (w_rd_ptr),
    .o_full    (w_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) r_state[i] <= INVALID;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (r_state[i] == WAIT && u_htu_refill_valid && w_entries[i].id == w_refill_id)
          r_state[i] <= READY;
      end
      if (w_deq) r_state[w_rd_ptr] <= INVALID;
      if (w_enq) r_state[w_wr_ptr] <= (u_htu_op[2] && !w_enq_bypass) ? WAIT : READY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crdt_valid   <= 1'b0;
      r_crdt_way_set <= '0;
    end else begin
      r_crdt_valid <= w_deq;
      if (w_deq) r_crdt_way_set <= w_head.id;
    end
  end

  assign d_exe_channel_1hot_id = w_head.channel_1hot_id;
  assign d_exe_op              = w_head.op;
  assign d_exe_id              = w_head.id;
  assign d_exe_offset          = w_head.offset;
  assign d_exe_wbuf_id         = w_head.wbuf_id;
  assign u_htu_crdt_valid      = r_crdt_valid;
  assign u_htu_crdt_way_set    = r_crdt_way_set;

endmodule

// File: tb/tb_isu_pend_queue.sv
// Scoreboard bench for isu_pend_queue: expected dispatches and credits are queued
// at enqueue time and a negedge monitor pops and compares them.
module tb_isu_pend_queue;
  import mpc_types::*;

  typedef struct packed {
    logic [2:0] ch;
    logic [2:0] op;
    logic [5:0] id;
    logic [2:0] off;
    logic [1:0] wb;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       u_htu_valid;
  logic       u_htu_ready;
  logic [2:0] u_htu_channel_1hot_id;
  logic [2:0] u_htu_op;
  logic [5:0] u_htu_id;
  logic [2:0] u_htu_offset;
  logic [1:0] u_htu_wbuf_id;
  logic       u_htu_refill_valid;
  logic [3:0] u_htu_refill_set;
  logic [1:0] u_htu_refill_way;
  logic       d_exe_valid;
  logic       d_exe_ready;
  logic [2:0] d_exe_channel_1hot_id;
  logic [2:0] d_exe_op;
  logic [5:0] d_exe_id;
  logic [2:0] d_exe_offset;
  logic [1:0] d_exe_wbuf_id;
  logic       u_htu_crdt_valid;
  logic [5:0] u_htu_crdt_way_set;

  int n_tests = 0;
  int n_fail  = 0;
  rec_t       dq[$];
  logic [5:0] cq[$];

  isu_pend_queue dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .u_htu_valid           (u_htu_valid),
    .u_htu_ready           (u_htu_ready),
    .u_htu_channel_1hot_id (u_htu_channel_1hot_id),
    .u_htu_op              (u_htu_op),
    .u_htu_id              (u_htu_id),
    .u_htu_offset          (u_htu_offset),
    .u_htu_wbuf_id         (u_htu_wbuf_id),
    .u_htu_refill_valid    (u_htu_refill_valid),
    .u_htu_refill_set      (u_htu_refill_set),
    .u_htu_refill_way      (u_htu_refill_way),
    .d_exe_valid           (d_exe_valid),
    .d_exe_ready           (d_exe_ready),
    .d_exe_channel_1hot_id (d_exe_channel_1hot_id),
    .d_exe_op              (d_exe_op),
    .d_exe_id              (d_exe_id),
    .d_exe_offset          (d_exe_offset),
    .d_exe_wbuf_id         (d_exe_wbuf_id),
    .u_htu_crdt_valid      (u_htu_crdt_valid),
    .u_htu_crdt_way_set    (u_htu_crdt_way_set)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted dispatch and every credit with the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (d_exe_valid && d_exe_ready) begin
        rec_t act;
        act = '{ch: d_exe_channel_1hot_id, op: d_exe_op, id: d_exe_id,
                off: d_exe_offset, wb: d_exe_wbuf_id};
        n_tests++;
        if (dq.size() == 0) begin
          n_fail++;
          $display("FAIL dispatch_unexpected: got %0h expected none", act);
        end else begin
          rec_t exp;
          exp = dq.pop_front();
          if (act !== exp) begin
            n_fail++;
            $display("FAIL dispatch: got %0h expected %0h", act, exp);
          end
        end
      end
      if (u_htu_crdt_valid) begin
        n_tests++;
        if (cq.size() == 0) begin
          n_fail++;
          $display("FAIL credit_unexpected: got %0h expected none", u_htu_crdt_way_set);
        end else begin
          logic [5:0] e;
          e = cq.pop_front();
          if (u_htu_crdt_way_set !== e) begin
            n_fail++;
            $display("FAIL credit: got %0h expected %0h", u_htu_crdt_way_set, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [2:0] ch, input logic [2:0] op, input logic [1:0] way,
                     input logic [3:0] set, input logic [2:0] off, input logic [1:0] wb,
                     input logic rf = 1'b0);
    chk("enq_ready", {31'd0, u_htu_ready}, 32'd1);
    u_htu_valid           = 1'b1;
    u_htu_channel_1hot_id = ch;
    u_htu_op              = op;
    u_htu_id              = {way, set};
    u_htu_offset          = off;
    u_htu_wbuf_id         = wb;
    u_htu_refill_valid    = rf;
    u_htu_refill_way      = way;
    u_htu_refill_set      = set;
    dq.push_back('{ch: ch, op: op, id: {way, set}, off: off, wb: wb});
    cq.push_back({way, set});
    tick();
    u_htu_valid        = 1'b0;
    u_htu_refill_valid = 1'b0;
  endtask

  task automatic refill(input logic [1:0] way, input logic [3:0] set);
    u_htu_refill_valid = 1'b1;
    u_htu_refill_way   = way;
    u_htu_refill_set   = set;
    tick();
    u_htu_refill_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && (dq.size() != 0 || cq.size() != 0); i++) tick();
    chk({name, "_disp_left"}, dq.size(), 0);
    chk({name, "_crdt_left"}, cq.size(), 0);
  endtask

  initial begin
    logic bad;
    rst_n = 1'b0;
    u_htu_valid = 1'b0;
    u_htu_channel_1hot_id = '0;
    u_htu_op = '0;
    u_htu_id = '0;
    u_htu_offset = '0;
    u_htu_wbuf_id = '0;
    u_htu_refill_valid = 1'b0;
    u_htu_refill_set = '0;
    u_htu_refill_way = '0;
    d_exe_ready = 1'b1;
    #23 rst_n = 1'b1;
    tick();
    chk("rst_ready", {31'd0, u_htu_ready}, 32'd1);
    chk("rst_valid", {31'd0, d_exe_valid}, 32'd0);
    chk("rst_crdt",  {31'd0, u_htu_crdt_valid}, 32'd0);

    // hit pass-through
    enq(3'b001, OP_RD_HIT, 2'd2, 4'd5, 3'd3, 2'd1);
    chk("hit_latency", {31'd0, d_exe_valid}, 32'd1);
    tick();
    chk("hit_crdt_next", {31'd0, u_htu_crdt_valid}, 32'd1);
    chk("hit_crdt_id", {26'd0, u_htu_crdt_way_set}, {26'd0, 2'd2, 4'd5});
    wait_drain("hit");

    // miss held until refill
    enq(3'b010, OP_RD_MISS, 2'd1, 4'd7, 3'd0, 2'd2);
    bad = 1'b0;
    repeat (10) begin
      if (d_exe_valid) bad = 1'b1;
      tick();
    end
    chk("miss_hold", {31'd0, bad}, 32'd0);
    refill(2'd1, 4'd7);
    chk("miss_refill_latency", {31'd0, d_exe_valid}, 32'd1);
    wait_drain("miss");

    // head-of-line blocking
    enq(3'b100, OP_WR_MISS, 2'd0, 4'd3, 3'd5, 2'd3);
    enq(3'b001, OP_WR_HIT,  2'd1, 4'd4, 3'd6, 2'd0);
    tick();
    tick();
    chk("hol_block", {31'd0, d_exe_valid}, 32'd0);
    refill(2'd0, 4'd3);
    wait_drain("hol");

    // multi-match with same-cycle refill bypass
    enq(3'b010, OP_RD_MISS, 2'd3, 4'd9, 3'd1, 2'd1);
    enq(3'b100, OP_WR_MISS, 2'd3, 4'd9, 3'd2, 2'd2, 1'b1);
    chk("mm_first", {31'd0, d_exe_valid}, 32'd1);
    tick();
    chk("mm_second", {31'd0, d_exe_valid}, 32'd1);
    wait_drain("mm");

    // full / backpressure
    d_exe_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      enq(3'b001, OP_WR_HIT, 2'(i), 4'(i + 3), 3'(i), 2'(i + 1));
    chk("full_ready", {31'd0, u_htu_ready}, 32'd0);
    u_htu_valid = 1'b1;
    u_htu_op    = OP_RD_HIT;
    u_htu_id    = 6'h3f;
    repeat (3) tick();
    chk("full_hold", {31'd0, u_htu_ready}, 32'd0);
    u_htu_valid = 1'b0;
    d_exe_ready = 1'b1;
    wait_drain("full");
    chk("full_ready_back", {31'd0, u_htu_ready}, 32'd1);

    // reset mid-operation
    d_exe_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      enq(3'b010, OP_RD_HIT, 2'(i), 4'(i + 10), 3'(i), 2'(i));
    chk("rstmid_pending", {31'd0, d_exe_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_valid", {31'd0, d_exe_valid}, 32'd0);
    chk("rstmid_crdt",  {31'd0, u_htu_crdt_valid}, 32'd0);
    chk("rstmid_ready", {31'd0, u_htu_ready}, 32'd1);
    dq.delete();
    cq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    d_exe_ready = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      tick();
      if (d_exe_valid || u_htu_crdt_valid) bad = 1'b1;
    end
    chk("rstmid_no_stale", {31'd0, bad}, 32'd0);
    enq(3'b001, OP_RD_HIT, 2'd2, 4'd1, 3'd7, 2'd3);
    wait_drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
